neural_network_layer_feeder: RTL and testbench
==============================================

Name: neural_network_layer_feeder

Overview:
Responder/driver for the layer handshake: sits in front of one neural-network layer instance. It buffers one input vector, resets and starts the layer, serves the layer's indexed input reads, and captures the layer's signed output. The result goes out on a valid/ready stream. This is the supplier end of the req / index / ack_layer protocol that the layer initiates toward its inputs.

Parameters:
N_IN, 2, number of layer inputs per inference (≥1)
DW, 8, signed fixed-point data width (Q4 fraction, matching layer arithmetic)
IDX_W, 1, layer index bus width, equal to max(1, clog2(N_IN))
RST_CYCLES, 2, number of cycles layer_rst is pulsed before req (≥1)
TIMEOUT, 64, maximum cycles from req to layer_ack before error (≥2)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input beat valid
in_data  in  DW  signed input element, in index order 0..N_IN-1
in_ready  out  1  feeder accepts beat
layer_rst  out  1  reset to layer, equals rst OR the FSM pulse
layer_req  out  1  start request to layer
layer_idx  in  IDX_W  index the layer is currently reading
layer_data  out  DW  signed buf[layer_idx], combinational
layer_ack  in  1  layer_ack (level, held until layer reset)
layer_result  in  DW  signed layer output, valid when layer_ack=1
out_valid  out  1  result valid
out_data  out  DW  captured signed result
out_err  out  1  result invalid because of timeout
out_ready  in  1  downstream accepts result
infer_count  out  16  completed inferences, including timeouts; wraps at 65535→0

Behaviour:
- Reset (async assert, sync release):
  - state=FILL, wptr=0, buf cleared to 0.
  - in_ready=1, layer_req=0, layer_rst=1 (through the rst OR term).
  - out_valid=0, out_data=0, out_err=0, infer_count=0.
- FSM state FILL:
  - in_ready=1.
  - On in_valid&in_ready: buf[wptr]<=in_data, wptr++.
  - The beat with wptr==N_IN-1 sets wptr<=0 and moves to LRST.
- FSM state LRST:
  - layer_rst=1 for exactly RST_CYCLES cycles (down-counter), in_ready=0.
  - Then moves to REQ.
- FSM state REQ:
  - layer_req=1 and the timeout counter increments each cycle.
  - If layer_ack=1 is sampled: out_data<=layer_result, out_err<=0, layer_req<=0, go to OUT.
  - Else if the counter reaches TIMEOUT-1: out_data<=0, out_err<=1, go to OUT.
  - If ack and timeout occur in the same cycle, ack wins.
- FSM state OUT:
  - out_valid=1, with out_data/out_err held stable.
  - On out_ready: infer_count++, go to FILL.
  - in_ready=0 throughout OUT, so the next vector cannot overlap.
- Latency:
  - Last input beat accepted at cycle t → layer_rst high over t+1..t+RST_CYCLES → layer_req high from t+RST_CYCLES+1.
  - out_valid rises the cycle after layer_ack is sampled.
- Buffer:
  - Written only in FILL, so layer_data is stable throughout LRST/REQ.
  - layer_idx ≥ N_IN returns 0.
  - Index wrap is owned by the layer.
- Arithmetic: none on data; values pass through as signed DW. Counters are unsigned.
- Mid-operation reset:
  - Aborts any state and returns to FILL with the buffer cleared.
  - The layer is reset concurrently via layer_rst.
- Stray layer_ack outside REQ is ignored.

Decomposition:
- Shared package neural_network_pkg holds:
  - DW and the fixed-point fraction-bits constant (4).
  - A signed data typedef.
  - The feeder state enum {FILL, LRST, REQ, OUT}.
- One sub-module, neural_network_feeder_buf: an N_IN×DW register file with a write port and a combinational indexed read port that returns 0 when out of range.

Test Plan:
Bench uses a layer model that acks 5 cycles after req with result = data[0] − data[1].
- Basic: in 16 then 5 (N_IN=2) → layer_rst high 2 cycles → req → out_valid with out_data=11, out_err=0, infer_count=1 after out_ready.
- Negative/backpressure: in −11 then 14, out_ready held low 10 cycles → out_data=−25 held stable over all 10 cycles; in_ready=0 throughout.
- Timeout: model never acks → out_valid exactly TIMEOUT cycles after req rise, out_data=0, out_err=1; next vector (3,1) yields out_data=2.
- Gapped input: in_valid toggles 1,0,0,1 with in 7 and 2 → exactly two writes; out_data=5; layer_data follows layer_idx 0→7, 1→2.
- Reset mid-REQ: assert rst during REQ → all outputs at reset values immediately (async); after release, in 4 then 4 → out_data=0, infer_count=1.
- Counter wrap: preload or run 65536 inferences → infer_count returns to 0.

Source files
------------

// File: rtl/neural_network_pkg.sv
// Shared types for the layer feeder: data width, fixed-point format and feeder FSM states.
`default_nettype none

package neural_network_pkg;

  localparam int DATA_W    = 8;
  localparam int FRAC_BITS = 4;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LRST = 2'd1,
    REQ  = 2'd2,
    OUT  = 2'd3
  } feeder_state_e;

endpackage

`default_nettype wire

// File: rtl/neural_network_feeder_buf.sv
// Input-vector register file: one write port, combinational indexed read (0 beyond N_IN).
`default_nettype none

module neural_network_feeder_buf
  import neural_network_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int DW    = DATA_W,
  parameter int IDX_W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic signed [DW-1:0] wr_data_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic signed [DW-1:0] rd_data_o
);

  localparam int DEPTH = 1 << IDX_W;

  logic signed [DW-1:0] ent [DEPTH];

  // Slots past N_IN are tied to zero so out-of-range reads need no compare.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (i < N_IN) begin : g_live
      logic signed [DW-1:0] entry_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_q <= '0;
        end else if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
          entry_q <= wr_data_i;
        end
      end
      assign ent[i] = entry_q;
    end else begin : g_pad
      assign ent[i] = '0;
    end
  end

  assign rd_data_o = ent[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/neural_network_layer_feeder.sv
// Drives one layer: buffers an input vector, pulses layer reset, requests, and returns the result on a stream.
`default_nettype none

module neural_network_layer_feeder
  import neural_network_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int DW         = DATA_W,
  parameter int IDX_W      = 1,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic                 layer_rst,
  output logic                 layer_req,
  input  logic [IDX_W-1:0]     layer_idx,
  output logic signed [DW-1:0] layer_data,
  input  logic                 layer_ack,
  input  logic signed [DW-1:0] layer_result,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic                 out_err,
  input  logic                 out_ready,
  output logic [15:0]          infer_count
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TO_W = $clog2(TIMEOUT);

  feeder_state_e        state_q;
  logic [IDX_W-1:0]     wptr_q;
  logic [RC_W-1:0]      rcnt_q;
  logic [TO_W-1:0]      tcnt_q;
  logic                 in_ready_q;
  logic                 lrst_q;
  logic                 req_q;
  logic                 out_valid_q;
  logic signed [DW-1:0] out_data_q;
  logic                 out_err_q;
  logic [15:0]          infer_count_q;
  logic                 wr_en;

  assign wr_en = (state_q == FILL) && in_valid && in_ready_q;

  neural_network_feeder_buf #(
    .N_IN (N_IN),
    .DW   (DW),
    .IDX_W(IDX_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_en),
    .wr_idx_i (wptr_q),
    .wr_data_i(in_data),
    .rd_idx_i (layer_idx),
    .rd_data_o(layer_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      wptr_q        <= '0;
      rcnt_q        <= '0;
      tcnt_q        <= '0;
      in_ready_q    <= 1'b1;
      lrst_q        <= 1'b0;
      req_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_err_q     <= 1'b0;
      infer_count_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid && in_ready_q) begin
            if (wptr_q == IDX_W'(N_IN - 1)) begin
              wptr_q     <= '0;
              in_ready_q <= 1'b0;
              lrst_q     <= 1'b1;
              rcnt_q     <= RC_W'(RST_CYCLES - 1);
              state_q    <= LRST;
            end else begin
              wptr_q <= wptr_q + IDX_W'(1);
            end
          end
        end
        LRST: begin
          if (rcnt_q == '0) begin
            lrst_q  <= 1'b0;
            req_q   <= 1'b1;
            tcnt_q  <= '0;
            state_q <= REQ;
          end else begin
            rcnt_q <= rcnt_q - RC_W'(1);
          end
        end
        REQ: begin
          // A late ack on the final timeout cycle still delivers real data.
          if (layer_ack) begin
            out_data_q  <= layer_result;
            out_err_q   <= 1'b0;
            req_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
            out_data_q  <= '0;
            out_err_q   <= 1'b1;
            req_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            tcnt_q <= tcnt_q + TO_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            infer_count_q <= infer_count_q + 16'd1;
            state_q       <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign layer_rst   = rst | lrst_q;
  assign layer_req   = req_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_err     = out_err_q;
  assign infer_count = infer_count_q;

endmodule

`default_nettype wire

// File: tb/tb_neural_network_layer_feeder.sv
// Self-checking bench for neural_network_layer_feeder with a behavioural layer and a result scoreboard.
`default_nettype none

module tb_neural_network_layer_feeder;
  import neural_network_pkg::*;

  localparam int TIMEOUT = 64;

  typedef struct packed {
    data_t data;
    logic  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  data_t       in_data;
  logic        in_ready;
  logic        layer_rst;
  logic        layer_req;
  logic [0:0]  layer_idx;
  data_t       layer_data;
  logic        layer_ack;
  data_t       layer_result;
  logic        out_valid;
  data_t       out_data;
  logic        out_err;
  logic        out_ready;
  logic [15:0] infer_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  logic       ack_en;
  logic       idx_ovr;
  logic [0:0] idx_tb;
  int         mcnt;
  data_t      m0, m1;

  neural_network_layer_feeder #(
    .N_IN(2), .DW(8), .IDX_W(1), .RST_CYCLES(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .layer_rst(layer_rst), .layer_req(layer_req), .layer_idx(layer_idx),
    .layer_data(layer_data), .layer_ack(layer_ack), .layer_result(layer_result),
    .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
    .out_ready(out_ready), .infer_count(infer_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Layer model: reads idx 0 then 1, acks 5 cycles after req with data[0]-data[1].
  always @(posedge clk or posedge layer_rst) begin
    if (layer_rst) begin
      layer_ack <= 1'b0;
      mcnt      <= 0;
      m0        <= '0;
      m1        <= '0;
    end else if (layer_req && ack_en && !layer_ack) begin
      mcnt <= mcnt + 1;
      if (mcnt == 0) m0 <= layer_data;
      if (mcnt == 1) m1 <= layer_data;
      if (mcnt == 4) layer_ack <= 1'b1;
    end
  end
  assign layer_result = m0 - m1;
  assign layer_idx    = idx_ovr ? idx_tb : 1'(mcnt == 1);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_out_data", 32'(out_data), 32'(e.data));
        check("sb_out_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input data_t d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    int k;
    k = 0;
    while (!out_valid && k < max) begin
      step();
      k++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_out(input logic [15:0] exp_cnt);
    wait_valid(200);
    step();
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("infer_count", 32'(infer_count), 32'(exp_cnt));
  endtask

  initial begin
    int r;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    ack_en = 1'b0; idx_ovr = 1'b0; idx_tb = '0;
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_layer_req", 32'(layer_req), 32'd0);
    check("rst_layer_rst", 32'(layer_rst), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_infer_count", 32'(infer_count), 32'd0);
    rst = 1'b0;
    step();

    // Basic
    ack_en = 1'b1; out_ready = 1'b1;
    sb_q.push_back('{data: 8'sd11, err: 1'b0});
    send(8'sd16); send(8'sd5);
    check("lrst_c1", 32'(layer_rst), 32'd1);
    check("lrst_in_ready", 32'(in_ready), 32'd0);
    step();
    check("lrst_c2", 32'(layer_rst), 32'd1);
    check("lrst_c2_req", 32'(layer_req), 32'd0);
    step();
    check("lrst_done", 32'(layer_rst), 32'd0);
    check("req_rise", 32'(layer_req), 32'd1);
    finish_out(16'd1);

    // Negative result with backpressure
    out_ready = 1'b0;
    sb_q.push_back('{data: -8'sd25, err: 1'b0});
    send(-8'sd11); send(8'sd14);
    wait_valid(100);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'(-8'sd25));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_infer_count", 32'(infer_count), 32'd2);

    // Timeout
    ack_en = 1'b0;
    sb_q.push_back('{data: 8'sd0, err: 1'b1});
    send(8'sd1); send(8'sd1);
    step(); step();
    check("to_req_rise", 32'(layer_req), 32'd1);
    r = cyc;
    wait_valid(TIMEOUT + 10);
    check("to_latency", 32'(cyc - r), 32'(TIMEOUT));
    step();
    check("to_infer_count", 32'(infer_count), 32'd3);
    ack_en = 1'b1;
    sb_q.push_back('{data: 8'sd2, err: 1'b0});
    send(8'sd3); send(8'sd1);
    finish_out(16'd4);

    // Gapped input and layer_data read-through
    sb_q.push_back('{data: 8'sd5, err: 1'b0});
    in_valid = 1'b1; in_data = 8'sd7; step();
    in_valid = 1'b0; in_data = 8'sd99; step(); step();
    in_valid = 1'b1; in_data = 8'sd2; step();
    in_valid = 1'b0;
    check("gap_in_ready", 32'(in_ready), 32'd0);
    idx_ovr = 1'b1; idx_tb = 1'b0; #1;
    check("gap_ldata0", 32'(layer_data), 32'(8'sd7));
    idx_tb = 1'b1; #1;
    check("gap_ldata1", 32'(layer_data), 32'(8'sd2));
    idx_ovr = 1'b0;
    finish_out(16'd5);

    // Reset during REQ
    ack_en = 1'b0;
    send(8'sd9); send(8'sd1);
    step(); step(); step();
    check("mid_req_active", 32'(layer_req), 32'd1);
    rst = 1'b1; #1;
    check("mid_rst_layer_rst", 32'(layer_rst), 32'd1);
    check("mid_rst_req", 32'(layer_req), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_infer", 32'(infer_count), 32'd0);
    idx_ovr = 1'b1; idx_tb = 1'b0; #1;
    check("mid_rst_buf0", 32'(layer_data), 32'd0);
    idx_tb = 1'b1; #1;
    check("mid_rst_buf1", 32'(layer_data), 32'd0);
    idx_ovr = 1'b0;
    step();
    rst = 1'b0;
    step();
    ack_en = 1'b1;
    sb_q.push_back('{data: 8'sd0, err: 1'b0});
    send(8'sd4); send(8'sd4);
    finish_out(16'd1);

    // Counter wrap from a preloaded value
    force dut.infer_count_q = 16'hFFFE;
    step();
    release dut.infer_count_q;
    sb_q.push_back('{data: 8'sd16, err: 1'b0});
    send(8'sd8); send(-8'sd8);
    finish_out(16'hFFFF);
    sb_q.push_back('{data: -8'sd5, err: 1'b0});
    send(8'sd0); send(8'sd5);
    finish_out(16'h0000);

    step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
